// File: rtl/alt_vipitc120_common_mode_select.sv
// Binary-to-one-hot mode selector: accepts a mode code via valid/ready and commits it as a
// registered one-hot vector only at a frame boundary (sof) or after an optional timeout.
module alt_vipitc120_common_mode_select #(
  parameter int unsigned NO_OF_MODES      = 3,
  parameter int unsigned LOG2_NO_OF_MODES = 2,
  parameter int unsigned RESET_MODE       = 0,
  parameter int unsigned SOF_TIMEOUT      = 0,
  parameter int unsigned TIMEOUT_WIDTH    = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [LOG2_NO_OF_MODES-1:0] req_binary,
  input  logic                        sof,
  output logic [NO_OF_MODES-1:0]      one_hot,
  output logic [LOG2_NO_OF_MODES-1:0] binary_current,
  output logic                        mode_changed,
  output logic                        req_invalid,
  output logic                        pending,
  output logic                        timed_out
);

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  localparam logic [LOG2_NO_OF_MODES-1:0] ResetCode = LOG2_NO_OF_MODES'(RESET_MODE);
  localparam logic [TIMEOUT_WIDTH-1:0] TimeoutLast =
      (SOF_TIMEOUT == 0) ? '0 : TIMEOUT_WIDTH'(SOF_TIMEOUT - 1);

  // Code 0 decodes to all zeros; code k sets only bit k-1.
  function automatic logic [NO_OF_MODES-1:0] decode(input logic [LOG2_NO_OF_MODES-1:0] code);
    logic [NO_OF_MODES-1:0] v;
    v = '0;
    for (int i = 0; i < NO_OF_MODES; i++) begin
      v[i] = (int'(code) == i + 1);
    end
    return v;
  endfunction

  state_e                        state_q, state_d;
  logic [LOG2_NO_OF_MODES-1:0]   pend_q, pend_d;
  logic [TIMEOUT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [NO_OF_MODES-1:0]        one_hot_q, one_hot_d;
  logic [LOG2_NO_OF_MODES-1:0]   binary_q, binary_d;
  logic                          changed_q, changed_d;
  logic                          invalid_q, invalid_d;
  logic                          timed_out_q, timed_out_d;

  logic code_ok;
  logic expire;

  assign code_ok = (int'(req_binary) <= int'(NO_OF_MODES));
  assign expire  = (SOF_TIMEOUT != 0) && (cnt_q == TimeoutLast);

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    one_hot_d   = one_hot_q;
    binary_d    = binary_q;
    changed_d   = 1'b0;
    invalid_d   = 1'b0;
    timed_out_d = 1'b0;
    case (state_q)
      StIdle: begin
        // sof is deliberately ignored here, even in the accepting cycle.
        if (req_valid) begin
          if (code_ok) begin
            pend_d  = req_binary;
            cnt_d   = '0;
            state_d = StPending;
          end else begin
            invalid_d = 1'b1;
          end
        end
      end
      StPending: begin
        if ((SOF_TIMEOUT != 0) && (cnt_q != '1)) begin
          cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
        end
        if (sof || expire) begin
          binary_d    = pend_q;
          one_hot_d   = decode(pend_q);
          changed_d   = 1'b1;
          timed_out_d = ~sof;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      cnt_q       <= '0;
      one_hot_q   <= decode(ResetCode);
      binary_q    <= ResetCode;
      changed_q   <= 1'b0;
      invalid_q   <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      one_hot_q   <= one_hot_d;
      binary_q    <= binary_d;
      changed_q   <= changed_d;
      invalid_q   <= invalid_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign req_ready      = (state_q == StIdle);
  assign pending        = (state_q == StPending);
  assign one_hot        = one_hot_q;
  assign binary_current = binary_q;
  assign mode_changed   = changed_q;
  assign req_invalid    = invalid_q;
  assign timed_out      = timed_out_q;

endmodule

// File: tb/tb_alt_vipitc120_common_mode_select.sv
// Bench for alt_vipitc120_common_mode_select: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a behavioural model.
module tb_alt_vipitc120_common_mode_select;

  localparam int NoModes = 3;
  localparam int Log2    = 3;
  localparam int RstMode = 2;
  localparam int Timeout = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [Log2-1:0] req_binary = '0;
  logic            sof = 1'b0;
  logic [2:0]      one_hot;
  logic [Log2-1:0] binary_current;
  logic            mode_changed, req_invalid, pending, timed_out;

  int checks = 0;
  int errors = 0;

  alt_vipitc120_common_mode_select #(
    .NO_OF_MODES     (NoModes),
    .LOG2_NO_OF_MODES(Log2),
    .RESET_MODE      (RstMode),
    .SOF_TIMEOUT     (Timeout),
    .TIMEOUT_WIDTH   (24)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_binary    (req_binary),
    .sof           (sof),
    .one_hot       (one_hot),
    .binary_current(binary_current),
    .mode_changed  (mode_changed),
    .req_invalid   (req_invalid),
    .pending       (pending),
    .timed_out     (timed_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: the active mode code, and an outstanding request with its entry cycle.
  int model_ok = 0;
  int cyc = 0;
  int m_mode, m_code, m_entry;
  bit m_pend, m_chg, m_inv, m_to;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      m_mode   <= RstMode;
      m_pend   <= 1'b0;
      m_chg    <= 1'b0;
      m_inv    <= 1'b0;
      m_to     <= 1'b0;
      model_ok <= 1;
    end else begin
      m_chg <= 1'b0;
      m_inv <= 1'b0;
      m_to  <= 1'b0;
      if (!m_pend) begin
        if (req_valid) begin
          if (int'(req_binary) > NoModes) begin
            m_inv <= 1'b1;
          end else begin
            m_pend  <= 1'b1;
            m_code  <= int'(req_binary);
            m_entry <= cyc + 1;
          end
        end
      end else if (sof || (cyc - m_entry >= Timeout - 1)) begin
        m_mode <= m_code;
        m_chg  <= 1'b1;
        m_to   <= !sof;
        m_pend <= 1'b0;
      end
    end
  end

  function automatic logic [31:0] exp_one_hot(input int mode);
    logic [31:0] v;
    v = 0;
    if (mode != 0) v = 32'd1 << (mode - 1);
    return v;
  endfunction

  always @(negedge clk) begin
    if (model_ok != 0) begin
      check("m_one_hot", 32'(one_hot), exp_one_hot(m_mode));
      check("m_binary", 32'(binary_current), 32'(m_mode));
      check("m_ready", 32'(req_ready), 32'(!m_pend));
      check("m_pending", 32'(pending), 32'(m_pend));
      check("m_changed", 32'(mode_changed), 32'(m_chg));
      check("m_invalid", 32'(req_invalid), 32'(m_inv));
      check("m_timed_out", 32'(timed_out), 32'(m_to));
    end
  end

  // Apply inputs for one cycle, then return just after the following falling edge.
  task automatic step(input bit v, input int code, input bit s);
    req_valid  = v;
    req_binary = Log2'(code);
    sof        = s;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 1'b0;
    check("rst_one_hot", 32'(one_hot), 32'b010);
    check("rst_binary", 32'(binary_current), 32'd2);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_pulses", {29'd0, mode_changed, req_invalid, timed_out}, 32'd0);

    // Basic commit on sof.
    step(1, 3, 0);
    for (int i = 0; i < 4; i++) begin
      check("basic_pending", 32'(pending), 32'd1);
      step(0, 0, 0);
    end
    step(0, 0, 1);
    check("basic_one_hot", 32'(one_hot), 32'b100);
    check("basic_binary", 32'(binary_current), 32'd3);
    check("basic_changed", 32'(mode_changed), 32'd1);
    check("basic_ready", 32'(req_ready), 32'd1);
    step(0, 0, 0);
    check("basic_pulse_len", 32'(mode_changed), 32'd0);

    // sof in the accepting cycle is ignored.
    step(1, 1, 1);
    check("ign_sof_pending", 32'(pending), 32'd1);
    check("ign_sof_one_hot", 32'(one_hot), 32'b100);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(0, 0, 1);
    check("ign_sof_commit", 32'(one_hot), 32'b001);

    // Out-of-range code.
    step(1, 5, 0);
    check("inv_pulse", 32'(req_invalid), 32'd1);
    check("inv_one_hot", 32'(one_hot), 32'b001);
    check("inv_pending", 32'(pending), 32'd0);
    step(0, 0, 0);
    check("inv_pulse_len", 32'(req_invalid), 32'd0);

    // Requests while pending are ignored.
    step(1, 2, 0);
    step(1, 3, 0);
    check("bp_ready", 32'(req_ready), 32'd0);
    step(1, 7, 0);
    check("bp_no_invalid", 32'(req_invalid), 32'd0);
    step(0, 0, 1);
    check("bp_binary", 32'(binary_current), 32'd2);

    // Timeout commit, then sof coinciding with expiry.
    step(1, 2, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0);
    check("to_not_yet", 32'(mode_changed), 32'd0);
    check("to_still_pending", 32'(pending), 32'd1);
    step(0, 0, 0);
    check("to_changed", 32'(mode_changed), 32'd1);
    check("to_timed_out", 32'(timed_out), 32'd1);
    check("to_one_hot", 32'(one_hot), 32'b010);
    step(1, 3, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0);
    step(0, 0, 1);
    check("to_sof_changed", 32'(mode_changed), 32'd1);
    check("to_sof_timed_out", 32'(timed_out), 32'd0);
    check("to_sof_one_hot", 32'(one_hot), 32'b100);

    // Reset while pending discards the request.
    step(1, 1, 0);
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
    step(0, 0, 1);
    check("mid_rst_one_hot", 32'(one_hot), 32'b010);
    check("mid_rst_changed", 32'(mode_changed), 32'd0);
    check("mid_rst_pending", 32'(pending), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
    end
    rst = 1'b0;
    step(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
